mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Initiator-side controller for the single-port word RAM, which has combinational read (rena/addr to data_out) and posedge write (wena, with word 0 write-protected). It accepts byte-addressed load/store requests from the core over a valid/ready handshake and sequences the RAM port. Sub-word stores are performed as read-modify-write. Loads are returned with sign or zero extension. Sits between the core's memory stage and the RAM instance.

Parameters:
DEPTH_WORDS, 10001, number of valid RAM words; word index >= DEPTH_WORDS is an error.
PROTECT_WORD0, 1, when 1, any store to word 0 returns an error and issues no write.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
req_signed  in  1  sign-extend the load result
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  core accepts the response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out of range, illegal size, or protected word
mem_rena  out  1  to RAM rena
mem_wena  out  1  to RAM wena
mem_addr  out  32  word index = req_addr[31:2]
mem_wdata  out  32  to RAM data_in
mem_rdata  in  32  from RAM data_out (Z when rena=0)

Behaviour:
- States: IDLE, READ, WRITE, RESP. Reset state is IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_rena=0, mem_wena=0, mem_addr=0, mem_wdata=0.
- IDLE: req_ready=1. When req_valid is high, latch the request and check it:
  - Misaligned if half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range if addr[31:2] >= DEPTH_WORDS.
  - Illegal if size=3.
  - Protected if PROTECT_WORD0=1, store, and addr[31:2]=0.
  - Any error: go to RESP with err=1; the RAM port is never touched.
  - Otherwise: a load or a sub-word store goes to READ; a word store goes to WRITE.
- READ (exactly 1 cycle): mem_rena=1, mem_addr=word index. Capture mem_rdata at the cycle's clock edge.
  - Load: extract the lane by addr[1:0]/size, extend per req_signed, go to RESP.
  - Sub-word store: merge req_wdata into the captured word at the addressed byte or half lane, go to WRITE.
- WRITE (exactly 1 cycle): mem_wena = (state==WRITE) & ~rst, with mem_addr and mem_wdata held, then go to RESP.
- RESP: resp_valid=1 until resp_ready; outputs are stable while stalled. On handshake go to IDLE. req_ready=0 in every state except IDLE, so there is no overlap.
- mem_rena=1 only in READ. Outside READ, mem_rdata is never sampled.
- Latency from the accept edge to resp_valid:
  - error: 1 cycle
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
- Little-endian lanes: byte lane k is bits [8k+7:8k]; half lane at addr[1] is bits [16*addr[1]+15 : 16*addr[1]].
- rst high mid-operation: return to IDLE at the next edge and drop any pending response. mem_wena is combinationally forced to 0 during the rst cycle, so no partial RMW write occurs.
- resp_ready high while resp_valid is low has no effect.

Decomposition:
- Package mem_access_pkg holds:
  - state enum {IDLE, READ, WRITE, RESP}
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
- One natural sub-module, mem_lane_align (combinational), provides:
  - load extract/extend (word, addr[1:0], size, signed -> 32b)
  - store merge (old word, wdata, addr[1:0], size -> 32b)

Test Plan:
- Preload word 5 = 0x8081_82F0. Load byte signed at addr 0x14 -> resp_rdata=0xFFFF_FFF0, err=0, 2-cycle latency. Load half unsigned at addr 0x16 -> 0x0000_8081.
- Word 5 = 0x1122_3344. Store byte 0xAB at addr 0x15 -> READ then WRITE with mem_wdata=0x1122_AB44, response at cycle 3. A subsequent load word at 0x14 returns 0x1122_AB44.
- Store word 0xDEAD_BEEF at addr 0x28 -> single WRITE cycle at mem_addr=10 with mem_rena=0, response at cycle 2.
- Each error case sees mem_rena=mem_wena=0 throughout, and resp_err=1 after 1 cycle:
  - load half at 0x13
  - store word at 0x0
  - load at word index 10001
  - size=3
- Hold resp_ready=0 for 4 cycles -> resp_valid and resp_rdata stay stable, req_ready=0, and a new req_valid is not accepted until the response handshake completes.
- Assert rst during the WRITE cycle of a byte store -> mem_wena=0 that cycle, target word unchanged, IDLE next cycle, no resp_valid.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access controller.
package mem_access_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Access size encodings on req_size. The value 3 is illegal.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends load data from a RAM
// word, and merges sub-word store data into an existing RAM word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,       // word read from the RAM
  input  logic [1:0]  addr_lo,    // byte offset within the word
  input  logic [1:0]  size,       // SZ_BYTE / SZ_HALF / SZ_WORD
  input  logic        is_signed,  // sign-extend the load result
  input  logic [31:0] wdata,      // right-aligned store data
  output logic [31:0] load_data,  // extracted and extended load value
  output logic [31:0] store_data  // word with the store lane merged in
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed lanes; a half lane is chosen by addr_lo[1] only.
  assign byte_lane = word[{addr_lo, 3'b000} +: 8];
  assign half_lane = word[{addr_lo[1], 4'b0000} +: 16];

  // Load extract and extend.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{is_signed & half_lane[15]}}, half_lane};
      default: load_data = word;
    endcase
  end

  // Store merge: replace only the addressed lane of the old word.
  always_comb begin
    store_data = word;
    case (size)
      SZ_BYTE: store_data[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a single-port word RAM. Accepts byte-addressed
// load/store requests, performs sub-word stores as read-modify-write, and
// returns extended load data or an error over a valid/ready response.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS   = 10001,
  parameter bit          PROTECT_WORD0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rena,
  output logic        mem_wena,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;
  logic [31:0] wdata_q;

  logic [29:0] word_idx;
  logic        misaligned;
  logic        out_of_range;
  logic        illegal_size;
  logic        protected_w;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_data;

  // Request checks, evaluated on the incoming request in IDLE.
  assign word_idx     = req_addr[31:2];
  assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign out_of_range = {2'b00, word_idx} >= DEPTH_WORDS;
  assign illegal_size = (req_size == 2'd3);
  assign protected_w  = PROTECT_WORD0 && req_we && (word_idx == 30'd0);
  assign req_err      = misaligned | out_of_range | illegal_size | protected_w;

  // Handshake and RAM strobes decode straight from the state.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_rena   = (state == READ);
  // Gated by rst so a reset landing on the write cycle cannot commit a partial RMW.
  assign mem_wena   = (state == WRITE) & ~rst;

  mem_lane_align u_align (
    .word       (mem_rdata),
    .addr_lo    (lo_q),
    .size       (size_q),
    .is_signed  (signed_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Request sequencing: latch and check, optional read, optional write, respond.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= SZ_BYTE;
      lo_q       <= 2'b00;
      wdata_q    <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            signed_q   <= req_signed;
            size_q     <= req_size;
            lo_q       <= req_addr[1:0];
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (req_err) begin
              state <= RESP;
            end else begin
              mem_addr <= {2'b00, word_idx};
              if (req_we && (req_size == SZ_WORD)) begin
                mem_wdata <= req_wdata;
                state     <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (we_q) begin
            mem_wdata <= store_data;
            state     <= WRITE;
          end else begin
            resp_rdata <= load_data;
            state      <= RESP;
          end
        end
        WRITE: begin
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural single-port RAM.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rena;
  logic        mem_wena;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_rena   (mem_rena),
    .mem_wena   (mem_wena),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, posedge write, word 0 write-protected.
  logic [31:0] ram [0:10000];
  logic        pl_en;
  logic [13:0] pl_idx;
  logic [31:0] pl_val;

  assign mem_rdata = mem_rena ? ram[mem_addr[13:0]] : 'z;

  always @(posedge clk) begin
    if (pl_en)
      ram[pl_idx] <= pl_val;
    else if (mem_wena && (mem_addr < 32'd10001) && (mem_addr != 32'd0))
      ram[mem_addr[13:0]] <= mem_wdata;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Per-transaction observations gathered by issue().
  int          lat;
  int          rena_cnt;
  logic        saw_wena;
  logic [31:0] w_addr;
  logic [31:0] w_data;

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = 14'(idx);
    pl_val = val;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Present one request, count edges from the accept edge until resp_valid.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    rena_cnt = 0;
    saw_wena = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (mem_rena) rena_cnt++;
      if (mem_wena) begin
        saw_wena = 1'b1;
        w_addr   = mem_addr;
        w_data   = mem_wdata;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (mem_rena) rena_cnt++;
    if (mem_wena) saw_wena = 1'b1;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, resp_valid, 1'b0);
  endtask

  // Full transaction with expected response, latency and RAM strobe activity.
  task automatic run(input string tag, input logic we, input logic [1:0] size,
                     input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                     input int exp_rena, input logic exp_wena);
    issue(we, size, sgn, addr, wdata);
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_err"},   resp_err, exp_err);
    check({tag, "_rena"},  rena_cnt, exp_rena);
    check({tag, "_wena"},  saw_wena, exp_wena);
    finish_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    pl_en      = 1'b0;
    pl_idx     = '0;
    pl_val     = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",  req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err",   resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_rena",   mem_rena, 1'b0);
    check("rst_mem_wena",   mem_wena, 1'b0);
    check("rst_mem_addr",   mem_addr, 32'h0);
    check("rst_mem_wdata",  mem_wdata, 32'h0);
    rst = 1'b0;

    // Loads with extension.
    preload(5, 32'h8081_82F0);
    run("ld_b_s",  1'b0, 2'd0, 1'b1, 32'h14, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 1, 1'b0);
    run("ld_h_u",  1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 32'h0000_8081, 1'b0, 2, 1, 1'b0);
    run("ld_h_s",  1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 32'hFFFF_8081, 1'b0, 2, 1, 1'b0);

    // Sub-word store by read-modify-write.
    preload(5, 32'h1122_3344);
    run("st_b",    1'b1, 2'd0, 1'b0, 32'h15, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 1'b1);
    check("st_b_waddr", w_addr, 32'd5);
    check("st_b_wdata", w_data, 32'h1122_AB44);
    check("st_b_ram",   ram[5], 32'h1122_AB44);
    run("ld_w",    1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h1122_AB44, 1'b0, 2, 1, 1'b0);
    run("ld_b3_u", 1'b0, 2'd0, 1'b0, 32'h17, 32'h0, 32'h0000_0011, 1'b0, 2, 1, 1'b0);

    // Sub-word half store into the upper lane.
    run("st_h",    1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF_5A5A, 32'h0, 1'b0, 3, 1, 1'b1);
    check("st_h_ram", ram[5], 32'h5A5A_AB44);

    // Word store: single write cycle, no read.
    run("st_w",    1'b1, 2'd2, 1'b0, 32'h28, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1'b1);
    check("st_w_waddr", w_addr, 32'd10);
    check("st_w_wdata", w_data, 32'hDEAD_BEEF);
    check("st_w_ram",   ram[10], 32'hDEAD_BEEF);

    // Error cases: RAM port untouched, response after one edge.
    run("err_misalign", 1'b0, 2'd1, 1'b0, 32'h13,     32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    run("err_protect",  1'b1, 2'd2, 1'b0, 32'h0,      32'h1, 32'h0, 1'b1, 1, 0, 1'b0);
    run("err_range",    1'b0, 2'd2, 1'b0, 32'h9C44,   32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    run("err_size",     1'b0, 2'd3, 1'b0, 32'h20,     32'h0, 32'h0, 1'b1, 1, 0, 1'b0);
    run("last_word",    1'b0, 2'd2, 1'b0, 32'h9C40,   32'h0, 32'hXXXX_XXXX, 1'b0, 2, 1, 1'b0);

    // Response stall: output held, new request refused.
    preload(5, 32'h1122_AB44);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
    check("stall_first_rdata", resp_rdata, 32'h1122_AB44);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h28;
    req_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid",     resp_valid, 1'b1);
      check("stall_rdata",     resp_rdata, 32'h1122_AB44);
      check("stall_req_ready", req_ready, 1'b0);
      check("stall_no_wena",   mem_wena, 1'b0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("stall_done_valid", resp_valid, 1'b0);
    check("stall_done_ready", req_ready, 1'b1);
    check("stall_no_rena",    mem_rena, 1'b0);
    check("stall_ram10",      ram[10], 32'hDEAD_BEEF);

    // Reset landing on the write cycle of a byte store.
    preload(7, 32'h5566_7788);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h1D;
    req_wdata  = 32'h0000_0000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw_read", mem_rena, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("rstw_wena_pre", mem_wena, 1'b1);
    check("rstw_wdata",    mem_wdata, 32'h5566_0088);
    rst = 1'b1;
    #1;
    check("rstw_wena_gated", mem_wena, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_ram",        ram[7], 32'h5566_7788);
    check("rstw_resp_valid", resp_valid, 1'b0);
    check("rstw_req_ready",  req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("rstw_resp_valid2", resp_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
